// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, LSB first, one bit per clock.
// Start/Busy/Done handshake; results and flags hold until the next Done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Zero,
  output logic             Ovf
);

  // state  | meaning
  // S_IDLE | waiting for Start, last results held
  // S_RUN  | one operand bit per cycle, counter 0..WIDTH-1
  // S_DONE | one-cycle Done pulse; Start here re-accepts back-to-back

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_borrow;
  logic             r_zero;
  logic             r_ovf;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_part_nxt;
  logic             w_last;
  logic             w_accept;

  assign w_a        = r_a_sh[0];
  assign w_b        = r_b_sh[0];
  assign w_d        = w_a ^ w_b ^ r_br;
  assign w_br_nxt   = (~w_a & w_b) | (w_b & r_br) | (r_br & ~w_a);
  assign w_part_nxt = {w_d, r_part[WIDTH-1:1]};
  assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  // Busy is low in both IDLE and DONE, so either may accept a new operation.
  assign w_accept   = (r_state != S_RUN) && Start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = Start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_part   <= '0;
      r_cnt    <= '0;
      r_br     <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= A;
      r_b_sh  <= B;
      r_br    <= Bin;
      r_part  <= '0;
      r_cnt   <= '0;
      r_a_msb <= A[WIDTH-1];
      r_b_msb <= B[WIDTH-1];
    end else if (r_state == S_RUN) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_br   <= w_br_nxt;
      r_part <= w_part_nxt;
      r_cnt  <= r_cnt + CW'(1);
      // The bit computed on the last edge is the result MSB, so Ovf uses w_d directly.
      if (w_last) begin
        r_diff   <= w_part_nxt;
        r_borrow <= w_br_nxt;
        r_zero   <= (w_part_nxt == '0);
        r_ovf    <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
      end
    end
  end

  assign Busy   = (r_state == S_RUN);
  assign Done   = (r_state == S_DONE);
  assign Diff   = r_diff;
  assign Borrow = r_borrow;
  assign Zero   = r_zero;
  assign Ovf    = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed WIDTH=8 cases plus exhaustive WIDTH=4
// operands in shuffled order with random Start gaps, checked against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s8, bin8, busy8, done8, borrow8, zero8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       s4, bin4, busy4, done4, borrow4, zero4, ovf4;
  logic [3:0] a4, b4, diff4;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [63:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
  } res_t;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .Start(s8), .A(a8), .B(b8), .Bin(bin8),
    .Busy(busy8), .Done(done8), .Diff(diff8), .Borrow(borrow8), .Zero(zero8), .Ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .Start(s4), .A(a4), .B(b4), .Bin(bin4),
    .Busy(busy4), .Done(done4), .Diff(diff4), .Borrow(borrow4), .Zero(zero4), .Ovf(ovf4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned difference for Diff/Borrow, signed range test for Ovf.
  function automatic res_t model(input int w, input longint a, input longint b, input int bin);
    res_t   r;
    longint full, half, sa, sb, s;
    half     = longint'(1) << (w - 1);
    full     = a - b - bin;
    r.borrow = (full < 0);
    r.diff   = 64'(full & ((longint'(1) << w) - 1));
    r.zero   = (r.diff == 64'd0);
    sa       = (a >= half) ? a - 2 * half : a;
    sb       = (b >= half) ? b - 2 * half : b;
    s        = sa - sb - bin;
    r.ovf    = (s < -half) || (s >= half);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    s8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    tick();
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
  endtask

  task automatic wait8(output int cyc, output int busy_n);
    cyc = 0; busy_n = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) busy_n++;
      tick();
      cyc++;
    end
  endtask

  task automatic check8(input string tag, input res_t e);
    check({tag, "_busy_in_done"}, busy8, 1'b0);
    check({tag, "_diff"}, diff8, e.diff[7:0]);
    check({tag, "_borrow"}, borrow8, e.borrow);
    check({tag, "_zero"}, zero8, e.zero);
    check({tag, "_ovf"}, ovf8, e.ovf);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin);
    res_t e;
    int   cyc, busy_n;
    e = model(8, a, b, bin);
    start8(a, b, bin);
    wait8(cyc, busy_n);
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_busy_cycles"}, busy_n, 8);
    check8(tag, e);
  endtask

  initial begin
    res_t e, prev4;
    int   cyc, busy_n, idx, gap, off, extra_done;
    logic [3:0] ra, rb;
    logic       rbin;

    rst = 1'b1;
    s8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    s4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset8", {busy8, done8, diff8, borrow8, zero8, ovf8}, '0);
    check("reset4", {busy4, done4, diff4, borrow4, zero4, ovf4}, '0);

    // Directed WIDTH=8 cases.
    run8("basic", 8'h35, 8'h12, 1'b0);
    check("basic_const", diff8, 8'h23);
    tick();
    check("done_width8", done8, 1'b0);
    run8("wrap", 8'h00, 8'h01, 1'b0);
    run8("ovf", 8'h80, 8'h01, 1'b0);
    check("ovf_const", {diff8, ovf8}, {8'h7F, 1'b1});
    run8("eq0", 8'h05, 8'h05, 1'b0);
    run8("eq1", 8'h05, 8'h05, 1'b1);
    run8("ovf_bin", 8'h80, 8'h00, 1'b1);

    // Start with new operands in RUN cycle 3 must be ignored.
    tick();
    e = model(8, 8'h35, 8'h12, 0);
    start8(8'h35, 8'h12, 1'b0);
    tick(); tick();
    s8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
    tick();
    s8 = 1'b0;
    wait8(cyc, busy_n);
    check("ignore_latency", cyc, 5);
    check8("ignore", e);

    // Back-to-back: Start held in the Done cycle.
    e = model(8, 8'h20, 8'h03, 0);
    start8(8'h20, 8'h03, 1'b0);
    check("b2b_done_drop", done8, 1'b0);
    wait8(cyc, busy_n);
    check("b2b_done_to_done", cyc + 1, 9);
    check8("b2b", e);

    // Reset in RUN cycle 4 aborts without Done.
    start8(8'h35, 8'h12, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outputs", {busy8, done8, diff8, borrow8, zero8, ovf8}, '0);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) extra_done++;
    end
    check("rst_mid_no_done", extra_done, 0);
    run8("after_rst", 8'hC3, 8'h4A, 1'b1);

    // Exhaustive WIDTH=4 in shuffled order with random gaps and noise while busy.
    prev4 = '0;
    off = int'($urandom_range(0, 511));
    for (int i = 0; i < 512; i++) begin
      idx  = (i * 37 + off) % 512;
      ra   = idx[3:0];
      rb   = idx[7:4];
      rbin = idx[8];
      gap  = int'($urandom_range(0, 3));
      s4 = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        if (g == 0) check("r4_done_width", done4, 1'b0);
      end
      e = model(4, ra, rb, rbin);
      s4 = 1'b1; a4 = ra; b4 = rb; bin4 = rbin;
      tick();
      check("r4_no_done_after_accept", done4, 1'b0);
      cyc = 0;
      while (!done4 && cyc < 30) begin
        check("r4_stable", {diff4, borrow4, zero4, ovf4},
              {prev4.diff[3:0], prev4.borrow, prev4.zero, prev4.ovf});
        s4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        tick();
        cyc++;
      end
      s4 = 1'b0;
      check("r4_latency", cyc, 4);
      check("r4_busy_in_done", busy4, 1'b0);
      check("r4_result", {diff4, borrow4, zero4, ovf4},
            {e.diff[3:0], e.borrow, e.zero, e.ovf});
      prev4 = e;
    end
    tick();
    check("r4_final_done_width", done4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
